// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the round-robin multiplier scheduler.
// Optional build macro: MUL_SCHED_PRIO0_EN (used by rr_arbiter).
package mul_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_N_REQ   = 4;
    localparam int DEFAULT_WIDTH   = 6;
    localparam int DEFAULT_MUL_LAT = 6;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Default: pure round-robin over all requesters, searching upward from
// last_ptr+1 with wrap-around.
// With MUL_SCHED_PRIO0_EN defined: req[0] always wins when set; requesters
// 1..N_REQ-1 rotate among themselves starting after last_ptr.
module rr_arbiter
    import mul_sched_pkg::*;
#(
    parameter int  N_REQ = DEFAULT_N_REQ,
    localparam int IDW   = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_ptr,
    output logic [N_REQ-1:0] winner_oh,
    output logic [IDW-1:0]   winner_id,
    output logic             found
);

    logic [IDW-1:0] idx;

    // Scan candidates from farthest to nearest so the nearest set bit after last_ptr wins.
    always_comb begin
        winner_id = '0;
        found     = 1'b0;
        idx       = '0;
`ifdef MUL_SCHED_PRIO0_EN
        // Rotation restricted to 1..N_REQ-1; the N_REQ-1 bias keeps the sum non-negative.
        for (int k = N_REQ - 1; k >= 1; k--) begin
            idx = IDW'(((int'(last_ptr) + N_REQ - 2 + k) % (N_REQ - 1)) + 1);
            if (req[idx]) begin
                winner_id = idx;
                found     = 1'b1;
            end
        end
        if (req[0]) begin
            winner_id = '0;
            found     = 1'b1;
        end
`else
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IDW'((int'(last_ptr) + k) % N_REQ);
            if (req[idx]) begin
                winner_id = idx;
                found     = 1'b1;
            end
        end
`endif
    end

    // One-hot form of the winner index.
    always_comb begin
        winner_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            winner_oh[i] = found && (winner_id == IDW'(i));
        end
    end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one serial multiplier between N_REQ requesters: round-robin grant,
// operand latch, one-cycle load pulse, MUL_LAT-cycle wait, tagged result.
// Optional build macro: MUL_SCHED_PRIO0_EN (requester 0 gets fixed priority).
//
// Handshake: a requester raises req[i] with stable op_a/op_b slices and holds
// it until gnt[i] pulses for one cycle; operands are captured on that grant,
// and req[i] must drop the cycle after gnt. The result comes back later as a
// single-cycle res_valid strobe tagged with res_id; there is no back-pressure.
module mul_rr_scheduler
    import mul_sched_pkg::*;
#(
    parameter int  N_REQ   = DEFAULT_N_REQ,
    parameter int  WIDTH   = DEFAULT_WIDTH,
    parameter int  MUL_LAT = DEFAULT_MUL_LAT,
    localparam int IDW     = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   mul_load,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [2*WIDTH-1:0]     mul_product,
    output logic                   res_valid,
    output logic [IDW-1:0]         res_id,
    output logic [2*WIDTH-1:0]     res_product,
    output state_t                 dbg_state
);

    localparam int CW = $clog2(MUL_LAT + 1);

    state_t             state, nxt_state;
    logic [CW-1:0]      cnt, nxt_cnt;
    logic [IDW-1:0]     last_ptr, nxt_last_ptr;
    logic [IDW-1:0]     win_id, nxt_win_id;
    logic [N_REQ-1:0]   nxt_gnt;
    logic               nxt_busy, nxt_load, nxt_valid;
    logic [WIDTH-1:0]   nxt_a, nxt_b;
    logic [IDW-1:0]     nxt_res_id;
    logic [2*WIDTH-1:0] nxt_res_product;

    logic [N_REQ-1:0]   arb_oh;
    logic [IDW-1:0]     arb_id;
    logic               arb_found;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req       (req),
        .last_ptr  (last_ptr),
        .winner_oh (arb_oh),
        .winner_id (arb_id),
        .found     (arb_found)
    );

    assign dbg_state = state;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        nxt_state       = state;
        nxt_cnt         = cnt;
        nxt_last_ptr    = last_ptr;
        nxt_win_id      = win_id;
        nxt_gnt         = '0;
        nxt_load        = 1'b0;
        nxt_valid       = 1'b0;
        nxt_a           = mul_a;
        nxt_b           = mul_b;
        nxt_res_id      = res_id;
        nxt_res_product = res_product;
        unique case (state)
            IDLE: begin
                if (arb_found) begin
                    nxt_state  = LOAD;
                    nxt_win_id = arb_id;
                    nxt_gnt    = arb_oh;
                    nxt_load   = 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (arb_oh[i]) begin
                            nxt_a = op_a[i*WIDTH +: WIDTH];
                            nxt_b = op_b[i*WIDTH +: WIDTH];
                        end
                    end
                end
            end
            LOAD: begin
                nxt_state = RUN;
                nxt_cnt   = '0;
            end
            RUN: begin
                // The product is sampled on the MUL_LAT-th RUN cycle.
                if (cnt == CW'(MUL_LAT - 1)) begin
                    nxt_state       = DONE;
                    nxt_valid       = 1'b1;
                    nxt_res_id      = win_id;
                    nxt_res_product = mul_product;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            DONE: begin
                nxt_state = IDLE;
`ifdef MUL_SCHED_PRIO0_EN
                // Requester 0 sits outside the rotation, so it never moves the pointer.
                if (win_id != '0) begin
                    nxt_last_ptr = win_id;
                end
`else
                nxt_last_ptr = win_id;
`endif
            end
            default: nxt_state = IDLE;
        endcase
        nxt_busy = (nxt_state != IDLE);
    end

    // State, bookkeeping and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_ptr    <= IDW'(N_REQ - 1);
            win_id      <= '0;
            gnt         <= '0;
            busy        <= 1'b0;
            mul_load    <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_product <= '0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            last_ptr    <= nxt_last_ptr;
            win_id      <= nxt_win_id;
            gnt         <= nxt_gnt;
            busy        <= nxt_busy;
            mul_load    <= nxt_load;
            mul_a       <= nxt_a;
            mul_b       <= nxt_b;
            res_valid   <= nxt_valid;
            res_id      <= nxt_res_id;
            res_product <= nxt_res_product;
        end
    end

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Self-checking bench for mul_rr_scheduler: directed scenarios followed by
// random request traffic, all checked against a transaction-level model.
// Honors MUL_SCHED_PRIO0_EN when defined.
module tb_mul_rr_scheduler;
    import mul_sched_pkg::*;

    localparam int N   = 4;
    localparam int W   = 6;
    localparam int LAT = 6;
    localparam int IDW = 2;

    typedef struct {
        int             id;
        logic [2*W-1:0] prod;
        int             cyc;
    } ev_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req  = '0;
    logic [N*W-1:0] op_a = '0;
    logic [N*W-1:0] op_b = '0;
    logic [N-1:0]   gnt;
    logic           busy, mul_load, res_valid;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_product;
    logic [IDW-1:0] res_id;
    logic [2*W-1:0] res_product;
    state_t         dbg_state;

    mul_rr_scheduler #(.N_REQ(N), .WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .gnt         (gnt),
        .busy        (busy),
        .mul_load    (mul_load),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_product (res_product),
        .dbg_state   (dbg_state)
    );

    // Multiplier stand-in: garbage after the load pulse, true product from
    // the MUL_LAT-th cycle after the load cycle onward.
    int             m_rem = 0;
    logic [W-1:0]   m_a, m_b;
    always @(posedge clk) begin
        if (!rst) begin
            m_rem       <= 0;
            mul_product <= '0;
        end else if (mul_load) begin
            m_a         <= mul_a;
            m_b         <= mul_b;
            m_rem       <= LAT - 1;
            mul_product <= ({{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b}) ^ (2*W)'($urandom_range(1, 4095));
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) mul_product <= {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
        end
    end

    // ---------------- model state / scoreboard ----------------
    int             cyc = 0, n_tests = 0, n_fail = 0;
    int             idle_from = 0, last_m = N - 1;
    logic [W-1:0]   a_m [N];
    logic [W-1:0]   b_m [N];
    ev_t            exp_q[$];
    ev_t            gnt_log[$];
    ev_t            res_log[$];
    logic [N-1:0]   just_gnt = '0;
    bit             hold0 = 1'b0;
    logic [IDW-1:0] hold_id = '0;
    logic [2*W-1:0] hold_prod = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] mulx(input logic [W-1:0] a, input logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // Next owner under the arbitration rules, given pending requests and last served.
    function automatic int pick(input logic [N-1:0] r);
`ifdef MUL_SCHED_PRIO0_EN
        if (r[0]) return 0;
        for (int k = 1; k < N; k++) begin
            int j = ((last_m - 1 + k) % (N - 1)) + 1;
            if (r[j]) return j;
        end
`else
        for (int k = 1; k <= N; k++) begin
            int j = (last_m + k) % N;
            if (r[j]) return j;
        end
`endif
        return 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            op_a[i*W +: W] = a_m[i];
            op_b[i*W +: W] = b_m[i];
        end
    endtask

    task automatic set_req(input int i, input int a, input int b);
        a_m[i] = W'(a);
        b_m[i] = W'(b);
        req[i] = 1'b1;
        drive_ops();
    endtask

    // Per-cycle comparison of DUT outputs with the model (called at negedge).
    task automatic monitor();
        int           w;
        ev_t          e;
        bit           exp_res;
        logic [N-1:0] oh;
        just_gnt = '0;
        if ((cyc - 1 >= idle_from) && (req != '0)) begin
            w = pick(req);
            oh = '0;
            oh[w] = 1'b1;
            check("gnt", gnt, oh);
            check("mul_load", mul_load, 1);
            check("mul_a", mul_a, a_m[w]);
            check("mul_b", mul_b, b_m[w]);
            e.id = w; e.prod = mulx(a_m[w], b_m[w]); e.cyc = cyc + LAT + 1;
            exp_q.push_back(e);
            e.cyc = cyc;
            gnt_log.push_back(e);
            idle_from = cyc + LAT + 2;
            if (!(hold0 && w == 0)) req[w] = 1'b0;
            just_gnt[w] = 1'b1;
            a_m[w] = W'($urandom);
            b_m[w] = W'($urandom);
            drive_ops();
        end else begin
            check("gnt_quiet", gnt, 0);
            check("mul_load_quiet", mul_load, 0);
        end
        check("busy", busy, (cyc < idle_from) ? 1 : 0);
        exp_res = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
        check("res_valid", res_valid, exp_res ? 1 : 0);
        if (exp_res) begin
            e = exp_q.pop_front();
            check("res_id", res_id, e.id);
            check("res_product", res_product, e.prod);
            e.cyc = cyc;
            res_log.push_back(e);
            hold_id = IDW'(e.id);
            hold_prod = e.prod;
`ifdef MUL_SCHED_PRIO0_EN
            if (e.id != 0) last_m = e.id;
`else
            last_m = e.id;
`endif
        end else begin
            check("res_id_hold", res_id, hold_id);
            check("res_product_hold", res_product, hold_prod);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst) monitor();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        req = '0;
        hold0 = 1'b0;
        repeat (n) tick();
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_load", mul_load, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_product", res_product, 0);
        check("rst_state", dbg_state, IDLE);
        exp_q.delete();
        last_m = N - 1;
        hold_id = '0;
        hold_prod = '0;
        rst = 1'b1;
        idle_from = cyc;
    endtask

    task automatic wait_res(input int n);
        int target = res_log.size() + n;
        int t = 0;
        while (res_log.size() < target && t < 200) begin
            tick();
            t++;
        end
        check("wait_res", res_log.size(), target);
    endtask

    task automatic wait_gnt(input int n);
        int target = gnt_log.size() + n;
        int t = 0;
        while (gnt_log.size() < target && t < 200) begin
            tick();
            t++;
        end
        check("wait_gnt", gnt_log.size(), target);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int t0, base, t;
        for (int i = 0; i < N; i++) begin
            a_m[i] = '0;
            b_m[i] = '0;
        end

        // Single request: 21 x 3, grant at +1, result at +LAT+2.
        do_reset(2);
        t0 = cyc;
        set_req(0, 21, 3);
        wait_res(1);
        check("single_gnt_id", gnt_log[gnt_log.size()-1].id, 0);
        check("single_gnt_lat", gnt_log[gnt_log.size()-1].cyc - t0, 1);
        check("single_res_lat", res_log[res_log.size()-1].cyc - t0, LAT + 2);
        check("single_res_id", res_log[res_log.size()-1].id, 0);
        check("single_product", res_log[res_log.size()-1].prod, 63);

        // Four simultaneous requests after reset: order 0,1,2,3, MUL_LAT+3 apart.
        do_reset(2);
        base = res_log.size();
        set_req(0, 5, 7);
        set_req(1, 9, 9);
        set_req(2, 63, 63);
        set_req(3, 0, 12);
        wait_res(4);
        check("sim_id0", res_log[base].id, 0);
        check("sim_id1", res_log[base+1].id, 1);
        check("sim_id2", res_log[base+2].id, 2);
        check("sim_id3", res_log[base+3].id, 3);
        check("sim_p0", res_log[base].prod, 35);
        check("sim_p1", res_log[base+1].prod, 81);
        check("sim_p2", res_log[base+2].prod, 3969);
        check("sim_p3", res_log[base+3].prod, 0);
        for (int k = 0; k < 3; k++)
            check("sim_gap", res_log[base+k+1].cyc - res_log[base+k].cyc, LAT + 3);

        // Wrap-around fairness: after serving 2, requester 0 goes before 2.
        set_req(2, 2, 3);
        wait_res(1);
        base = res_log.size();
        set_req(0, 1, 1);
        set_req(2, 4, 4);
        wait_res(2);
        check("wrap_first", res_log[base].id, 0);
        check("wrap_second", res_log[base+1].id, 2);
        check("wrap_p2", res_log[base+1].prod, 16);

        // Reset in RUN drops the job; a fresh 63 x 63 still completes.
        set_req(1, 10, 10);
        wait_gnt(1);
        repeat (3) tick();
        do_reset(1);
        repeat (12) tick();
        set_req(3, 63, 63);
        wait_res(1);
        check("post_rst_id", res_log[res_log.size()-1].id, 3);
        check("post_rst_product", res_log[res_log.size()-1].prod, 3969);

        // Operands changed during RUN do not disturb the latched job.
        set_req(1, 13, 11);
        wait_gnt(1);
        repeat (2) tick();
        a_m[1] = 6'd40;
        b_m[1] = 6'd50;
        drive_ops();
        wait_res(1);
        check("latched_product", res_log[res_log.size()-1].prod, 143);

`ifdef MUL_SCHED_PRIO0_EN
        // Fixed priority for requester 0 while it holds req; then 1 and 3 rotate.
        do_reset(2);
        hold0 = 1'b1;
        base = gnt_log.size();
        set_req(0, 3, 3);
        set_req(1, 4, 4);
        set_req(3, 5, 5);
        wait_gnt(3);
        for (int k = 0; k < 3; k++) check("prio0_hold", gnt_log[base+k].id, 0);
        hold0 = 1'b0;
        req[0] = 1'b0;
        wait_gnt(2);
        check("prio_rr_a", gnt_log[base+3].id, 1);
        check("prio_rr_b", gnt_log[base+4].id, 3);
        wait_res(5);
`endif

        // Random traffic against the model.
        repeat (600) begin
            tick();
            for (int i = 0; i < N; i++)
                if (!req[i] && !just_gnt[i] && $urandom_range(0, 3) == 0)
                    set_req(i, $urandom_range(0, 63), $urandom_range(0, 63));
        end
        t = 0;
        while ((req != '0 || exp_q.size() != 0) && t < 300) begin
            tick();
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        check("drain_req", req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
